eject_sink: RTL
===============

Name: eject_sink

Overview:
- Consumer stage on a router's local ejection output (out_staging port 0). One instance sits downstream of each router in the NoC top.
- Accepts every ejected flit unconditionally and returns a credit per flit after a configurable credit delay.
- Tracks packet framing per VC, counts delivered flits and packets, and flags protocol errors.
- Asserts done once the expected packet count has arrived and the sink has drained, so the top can end simulation.

Parameters:
- NUM_VC, 4, number of virtual channels tracked.
- VC_W, 2, width of VC field; 2**VC_W >= NUM_VC.
- DST_W, 14, destination field width.
- MY_ID, 0, router index this sink belongs to; compared against head-flit dst.
- CREDIT_DELAY, 1, cycles from flit acceptance to credit return; legal range 1..16.
- CNT_W, 16, width of counters and expected-packet register.

Ports:
- clk  in  1  clock, all logic on posedge.
- rst  in  1  synchronous active-high reset.
- in_valid  in  1  ejected flit present this cycle (BufferFull).
- in_vc  in  VC_W  flit VC.
- in_head  in  1  head flag.
- in_tail  in  1  tail flag.
- in_dst  in  DST_W  flit destination.
- cr_valid  out  1  credit return strobe.
- cr_vc  out  VC_W  VC being credited.
- exp_load  in  1  load exp_pkts into expected register.
- exp_pkts  in  CNT_W  number of packets expected at this sink.
- pkt_count  out  CNT_W  completed packets (tail accepted in IN_PKT).
- flit_count  out  CNT_W  accepted flits.
- err  out  4  sticky errors: [0] orphan body/tail, [1] nested head, [2] dst mismatch, [3] VC out of range.
- done  out  1  completion flag.

Behaviour:
- Reset values:
  - Registered outputs: all outputs 0, including cr_vc.
  - Internal state: every VC state = IDLE, credit pipe empty, expected register = 0.
  - rst mid-packet discards partial state and in-flight credits.
- Acceptance: a flit is accepted on any posedge with in_valid=1 and in_vc < NUM_VC. There is no backpressure; at most one flit per cycle.
- VC out of range:
  - When in_valid=1 and in_vc >= NUM_VC: set err[3].
  - The flit is not counted, not credited, and no VC state changes.
- flit_count increments on each accepted flit and saturates at all-ones.
- Per-VC FSM (IDLE, IN_PKT), indexed by in_vc:
  - IDLE, head & tail: single-flit packet, pkt_count+1, stay IDLE.
  - IDLE, head & !tail: go to IN_PKT.
  - IDLE, !head: set err[0], stay IDLE, no packet count.
  - IN_PKT, !head & tail: pkt_count+1, go to IDLE.
  - IN_PKT, !head & !tail: stay IN_PKT.
  - IN_PKT, head: set err[1]. The old packet is abandoned (not counted) and the new head is processed as if the VC were IDLE.
- Dst check: on every accepted head, in_dst != MY_ID sets err[2]. Framing and counting proceed normally.
- pkt_count saturates at all-ones.
- Credit return:
  - Each accepted flit launches {1, in_vc} into a CREDIT_DELAY-deep shift pipe.
  - cr_valid/cr_vc appear exactly CREDIT_DELAY cycles after the acceptance edge. CREDIT_DELAY=1 means registered on the next posedge.
  - One flit per cycle gives at most one credit per cycle, so no collision arbitration is needed.
  - When no credit emerges, cr_vc holds 0.
- Expected register:
  - exp_load=1 loads exp_pkts and clears done.
  - If exp_load coincides with a tail, the count update still happens.
- done: registered. Set when the expected register != 0, pkt_count >= expected, all VCs are IDLE and the credit pipe is empty. Once set it stays set until rst or exp_load.
- err bits are sticky until rst.

Optional Feature:
- Macro EJECT_PKTLEN_EN.
- When defined:
  - Adds a CNT_W-wide per-VC flit-length counter, reset to 1 on a head.
  - Adds an output max_pkt_len (CNT_W), reset 0, holding the longest completed packet length in flits. A single-flit packet has length 1.
  - Updated on the cycle after the completing tail.
- When undefined: neither the port nor the counters exist, and all other behaviour is identical.

Test Plan:
- Single-flit packet: after rst, exp_pkts=1 loaded; flit vc=1, head=1, tail=1, dst=MY_ID -> pkt_count=1, flit_count=1; cr_valid=1 with cr_vc=1 exactly CREDIT_DELAY cycles later; done=1 one cycle after the pipe drains; err=0.
- Interleaved VCs: vc0 head, vc2 head, vc0 body, vc2 tail, vc0 tail on consecutive cycles -> pkt_count=2, flit_count=5; five credits in the same VC order, each delayed by CREDIT_DELAY; err=0.
- Framing errors: vc0 body with no head -> err=4'b0001, pkt_count unchanged. Then vc0 head, head, tail -> err=4'b0011, pkt_count=1.
- Dst and range errors: head+tail with dst=MY_ID+1 -> err[2]=1 and pkt_count=1. Then a flit with in_vc=NUM_VC (only when NUM_VC < 2**VC_W) -> err[3]=1, flit_count unchanged, no credit.
- Reset mid-packet: vc3 head, then rst for 1 cycle while a credit is in flight -> all outputs 0 and no credit emerges. A following vc3 body sets err[0].
- Saturation/PKTLEN: CNT_W=4, send 17 single-flit packets -> pkt_count=15 and flit_count=15. With EJECT_PKTLEN_EN and a 5-flit packet -> max_pkt_len=5.

Source files
------------

// File: rtl/eject_sink_if.sv
// -----------------------------------------------------------------------------
// eject_sink_if
// Flit ejection bus between a router's local output port and its eject sink.
//   in_valid / in_vc / in_head / in_tail / in_dst : flit driven by the router
//   cr_valid / cr_vc                              : credit returned by the sink
// Modports:
//   master : router side (drives the flit, receives credits)
//   slave  : sink side   (receives the flit, drives credits)
// -----------------------------------------------------------------------------
interface eject_sink_if #(
   parameter int VC_W  = 2,
   parameter int DST_W = 14
);
   logic             in_valid;
   logic [VC_W-1:0]  in_vc;
   logic             in_head;
   logic             in_tail;
   logic [DST_W-1:0] in_dst;
   logic             cr_valid;
   logic [VC_W-1:0]  cr_vc;

   modport master (
      output in_valid, in_vc, in_head, in_tail, in_dst,
      input  cr_valid, cr_vc
   );

   modport slave (
      input  in_valid, in_vc, in_head, in_tail, in_dst,
      output cr_valid, cr_vc
   );
endinterface

// File: rtl/eject_sink.sv
// -----------------------------------------------------------------------------
// eject_sink
// Consumer on a router's local ejection port. Accepts every flit, returns one
// credit per accepted flit CREDIT_DELAY cycles later, tracks per-VC packet
// framing, counts flits/packets (saturating), keeps sticky protocol errors and
// raises done once the expected number of packets has arrived and drained.
//
// Ports:
//   clk, rst        : clock and synchronous active-high reset
//   flit_if (slave) : flit in (in_*), credit out (cr_*)
//   i_exp_load      : load i_exp_pkts into the expected-packet register
//   i_exp_pkts      : expected packet count
//   o_pkt_count     : completed packets
//   o_flit_count    : accepted flits
//   o_err           : sticky [0] orphan body/tail, [1] nested head,
//                     [2] dst mismatch, [3] VC out of range
//   o_done          : completion flag
//   o_max_pkt_len   : longest completed packet in flits (EJECT_PKTLEN_EN only)
//
// Optional feature macro: EJECT_PKTLEN_EN (per-VC length counters + max length)
// -----------------------------------------------------------------------------
module eject_sink #(
   parameter int NUM_VC       = 4,
   parameter int VC_W         = 2,
   parameter int DST_W        = 14,
   parameter int MY_ID        = 0,
   parameter int CREDIT_DELAY = 1,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   eject_sink_if.slave      flit_if,
   input  logic             i_exp_load,
   input  logic [CNT_W-1:0] i_exp_pkts,
   output logic [CNT_W-1:0] o_pkt_count,
   output logic [CNT_W-1:0] o_flit_count,
   output logic [3:0]       o_err,
   output logic             o_done
`ifdef EJECT_PKTLEN_EN
   ,
   output logic [CNT_W-1:0] o_max_pkt_len
`endif
);

   typedef enum logic {ST_IDLE = 1'b0, ST_IN_PKT = 1'b1} vc_state_t;

   localparam logic [31:0]      NUM_VC_L = NUM_VC;
   localparam logic [DST_W-1:0] MY_ID_L  = DST_W'(MY_ID);
   localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

   // Saturating increment shared by all counters.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] x);
      sat_inc = (x == CNT_MAX) ? x : (x + CNT_ONE);
   endfunction

   vc_state_t                r_state     [NUM_VC];
   vc_state_t                w_state_nxt [NUM_VC];
   logic [CREDIT_DELAY-1:0]  r_cr_v;
   logic [VC_W-1:0]          r_cr_vc     [CREDIT_DELAY];
   logic [CNT_W-1:0]         r_pkt;
   logic [CNT_W-1:0]         r_flit;
   logic [CNT_W-1:0]         r_exp;
   logic [3:0]               r_err;
   logic                     r_done;

   logic [31:0]              w_vc_ext;
   logic                     w_accept;
   logic                     w_range_err;
   logic                     w_dst_err;
   logic                     w_orphan;
   logic                     w_nested;
   logic                     w_pkt_done;
   logic                     w_all_idle;
   logic                     w_pipe_empty;

`ifdef EJECT_PKTLEN_EN
   logic [CNT_W-1:0]         r_len     [NUM_VC];
   logic [CNT_W-1:0]         w_len_nxt [NUM_VC];
   logic [CNT_W-1:0]         w_done_len;
   logic [CNT_W-1:0]         r_max;
`endif

   // Zero-extend the VC so the range test is a plain 32-bit compare.
   assign w_vc_ext     = {{(32-VC_W){1'b0}}, flit_if.in_vc};
   assign w_accept     = flit_if.in_valid & (w_vc_ext < NUM_VC_L);
   assign w_range_err  = flit_if.in_valid & ~(w_vc_ext < NUM_VC_L);
   assign w_dst_err    = w_accept & flit_if.in_head & (flit_if.in_dst != MY_ID_L);
   assign w_pipe_empty = (r_cr_v == {CREDIT_DELAY{1'b0}});

   // Per-VC framing FSM next state; only the addressed VC can move.
   always_comb begin
      w_orphan   = 1'b0;
      w_nested   = 1'b0;
      w_pkt_done = 1'b0;
      w_all_idle = 1'b1;
`ifdef EJECT_PKTLEN_EN
      w_done_len = CNT_ZERO;
`endif
      for (int v = 0; v < NUM_VC; v++) begin
         w_state_nxt[v] = r_state[v];
`ifdef EJECT_PKTLEN_EN
         w_len_nxt[v]   = r_len[v];
`endif
         w_all_idle = w_all_idle & (r_state[v] == ST_IDLE);
         if (w_accept && (w_vc_ext == $unsigned(v))) begin
            if (flit_if.in_head) begin
               // A head always starts afresh; an open packet is abandoned.
               w_nested = (r_state[v] == ST_IN_PKT);
`ifdef EJECT_PKTLEN_EN
               w_len_nxt[v] = CNT_ONE;
`endif
               if (flit_if.in_tail) begin
                  w_state_nxt[v] = ST_IDLE;
                  w_pkt_done     = 1'b1;
`ifdef EJECT_PKTLEN_EN
                  w_done_len     = CNT_ONE;
`endif
               end else begin
                  w_state_nxt[v] = ST_IN_PKT;
               end
            end else if (r_state[v] == ST_IDLE) begin
               w_orphan = 1'b1;
            end else begin
`ifdef EJECT_PKTLEN_EN
               w_len_nxt[v] = sat_inc(r_len[v]);
`endif
               if (flit_if.in_tail) begin
                  w_state_nxt[v] = ST_IDLE;
                  w_pkt_done     = 1'b1;
`ifdef EJECT_PKTLEN_EN
                  w_done_len     = sat_inc(r_len[v]);
`endif
               end else begin
                  w_state_nxt[v] = ST_IN_PKT;
               end
            end
         end else begin
            w_state_nxt[v] = r_state[v];
         end
      end
   end

   // Per-VC framing state register.
   always_ff @(posedge clk) begin
      for (int v = 0; v < NUM_VC; v++) begin
         if (rst) begin
            r_state[v] <= ST_IDLE;
         end else begin
            r_state[v] <= w_state_nxt[v];
         end
      end
   end

   // Credit shift pipe; idle slots carry VC 0 so cr_vc rests at 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cr_v <= {CREDIT_DELAY{1'b0}};
         for (int i = 0; i < CREDIT_DELAY; i++) begin
            r_cr_vc[i] <= {VC_W{1'b0}};
         end
      end else begin
         for (int i = CREDIT_DELAY - 1; i > 0; i--) begin
            r_cr_v[i]  <= r_cr_v[i-1];
            r_cr_vc[i] <= r_cr_vc[i-1];
         end
         r_cr_v[0]  <= w_accept;
         r_cr_vc[0] <= w_accept ? flit_if.in_vc : {VC_W{1'b0}};
      end
   end

   // Counters, sticky errors, expected register and completion flag.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_pkt  <= CNT_ZERO;
         r_flit <= CNT_ZERO;
         r_exp  <= CNT_ZERO;
         r_err  <= 4'b0000;
         r_done <= 1'b0;
      end else begin
         if (w_accept) begin
            r_flit <= sat_inc(r_flit);
         end
         if (w_pkt_done) begin
            r_pkt <= sat_inc(r_pkt);
         end
         r_err <= r_err | {w_range_err, w_dst_err, w_nested, w_orphan};
         if (i_exp_load) begin
            r_exp  <= i_exp_pkts;
            r_done <= 1'b0;
         end else if ((r_exp != CNT_ZERO) && (r_pkt >= r_exp) && w_all_idle && w_pipe_empty) begin
            r_done <= 1'b1;
         end
      end
   end

`ifdef EJECT_PKTLEN_EN
   // Per-VC packet length and longest completed packet.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_max <= CNT_ZERO;
         for (int v = 0; v < NUM_VC; v++) begin
            r_len[v] <= CNT_ZERO;
         end
      end else begin
         for (int v = 0; v < NUM_VC; v++) begin
            r_len[v] <= w_len_nxt[v];
         end
         if (w_pkt_done && (w_done_len > r_max)) begin
            r_max <= w_done_len;
         end
      end
   end

   assign o_max_pkt_len = r_max;
`endif

   assign flit_if.cr_valid = r_cr_v[CREDIT_DELAY-1];
   assign flit_if.cr_vc    = r_cr_vc[CREDIT_DELAY-1];
   assign o_pkt_count      = r_pkt;
   assign o_flit_count     = r_flit;
   assign o_err            = r_err;
   assign o_done           = r_done;

endmodule
